// File: rtl/sad_min_tracker.sv
// Three-stage SAD reduction of a 32x32 absolute-difference block, followed by
// running minima (full block and four 16x16 quadrants) with their MV tags.
module sad_min_tracker #(
    parameter int PIXEL = 8,
    parameter int MVW   = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [32*32*PIXEL-1:0]    abs_outs,
    input  logic                      abs_valid,
    input  logic signed [MVW-1:0]     mv_x,
    input  logic signed [MVW-1:0]     mv_y,
    input  logic                      search_start,
    input  logic                      search_last,
    output logic [17:0]               best_sad_32,
    output logic [2*MVW-1:0]          best_mv_32,
    output logic [63:0]               best_sad_16,
    output logic [8*MVW-1:0]          best_mv_16,
    output logic                      done
);

    localparam int HRW = PIXEL + 4;   // sum of 16 values
    localparam int QW  = 16;          // sum of 256 values
    localparam int FW  = 18;          // sum of 1024 values
    localparam int TW  = 2 * MVW;

    // ---------------- stage 1: half-row sums ----------------
    logic [HRW-1:0] hr_sum_next [64];
    logic [HRW-1:0] hr_sum_reg  [64];
    logic [TW-1:0]  tag1_reg;
    logic           valid1_reg, last1_reg;

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_half_row
            localparam int ROW  = gi / 2;
            localparam int HALF = gi % 2;
            logic [HRW-1:0] acc;
            always_comb begin
                acc = '0;
                for (int k = 0; k < 16; k++) begin
                    acc = acc + HRW'(abs_outs[(32*ROW + 16*HALF + k)*PIXEL +: PIXEL]);
                end
            end
            assign hr_sum_next[gi] = acc;
        end
    endgenerate

    // ---------------- stage 2: quadrant sums ----------------
    logic [QW-1:0] quad_next [4];
    logic [QW-1:0] quad2_reg [4];
    logic [TW-1:0] tag2_reg;
    logic          valid2_reg, last2_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quad
            // q0/q1 take the upper 16 rows, q2/q3 the lower; odd q is the right half
            localparam int RB   = (gi / 2) * 16;
            localparam int HALF = gi % 2;
            logic [QW-1:0] acc;
            always_comb begin
                acc = '0;
                for (int r = 0; r < 16; r++) begin
                    acc = acc + QW'(hr_sum_reg[2*(RB + r) + HALF]);
                end
            end
            assign quad_next[gi] = acc;
        end
    endgenerate

    // ---------------- stage 3: full SAD ----------------
    logic [FW-1:0] full_next;
    logic [FW-1:0] full3_reg;
    logic [QW-1:0] quad3_reg [4];
    logic [TW-1:0] tag3_reg;
    logic          valid3_reg, last3_reg;

    assign full_next = FW'(quad2_reg[0]) + FW'(quad2_reg[1])
                     + FW'(quad2_reg[2]) + FW'(quad2_reg[3]);

    // Datapath registers carry no reset; only the control flags need one.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 64; n++) begin
            hr_sum_reg[n] <= hr_sum_next[n];
        end
        tag1_reg <= {mv_x, mv_y};
        for (int q = 0; q < 4; q++) begin
            quad2_reg[q] <= quad_next[q];
            quad3_reg[q] <= quad2_reg[q];
        end
        tag2_reg  <= tag1_reg;
        full3_reg <= full_next;
        tag3_reg  <= tag2_reg;
    end

    // ---------------- minima ----------------
    logic [FW-1:0] min32_reg;
    logic [TW-1:0] mv32_reg;
    logic [QW-1:0] min16_reg [4];
    logic [TW-1:0] mv16_reg  [4];
    logic          done_reg;

    // A start pulse kills stages 2 and 3 but still admits a same-cycle candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_reg <= 1'b0;
            last1_reg  <= 1'b0;
            valid2_reg <= 1'b0;
            last2_reg  <= 1'b0;
            valid3_reg <= 1'b0;
            last3_reg  <= 1'b0;
            done_reg   <= 1'b0;
            min32_reg  <= '1;
            mv32_reg   <= '0;
            for (int q = 0; q < 4; q++) begin
                min16_reg[q] <= '1;
                mv16_reg[q]  <= '0;
            end
        end else begin
            valid1_reg <= abs_valid;
            last1_reg  <= abs_valid & search_last;
            valid2_reg <= valid1_reg & ~search_start;
            last2_reg  <= last1_reg & ~search_start;
            valid3_reg <= valid2_reg & ~search_start;
            last3_reg  <= last2_reg & ~search_start;
            done_reg   <= valid3_reg & last3_reg & ~search_start;
            if (search_start) begin
                min32_reg <= '1;
                mv32_reg  <= '0;
                for (int q = 0; q < 4; q++) begin
                    min16_reg[q] <= '1;
                    mv16_reg[q]  <= '0;
                end
            end else if (valid3_reg) begin
                // strict less-than keeps the earliest candidate on a tie
                if (full3_reg < min32_reg) begin
                    min32_reg <= full3_reg;
                    mv32_reg  <= tag3_reg;
                end
                for (int q = 0; q < 4; q++) begin
                    if (quad3_reg[q] < min16_reg[q]) begin
                        min16_reg[q] <= quad3_reg[q];
                        mv16_reg[q]  <= tag3_reg;
                    end
                end
            end
        end
    end

    assign best_sad_32 = min32_reg;
    assign best_mv_32  = mv32_reg;
    assign done        = done_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out
            assign best_sad_16[16*gi +: 16] = min16_reg[gi];
            assign best_mv_16[TW*gi +: TW]  = mv16_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sad_min_tracker.sv
// Directed bench for sad_min_tracker: a table of single-candidate searches plus
// hand-written multi-cycle sequences (ties, restart, reset mid-search).
module tb_sad_min_tracker;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [8191:0]     abs_outs;
    logic              abs_valid;
    logic signed [6:0] mv_x, mv_y;
    logic              search_start, search_last;
    logic [17:0]       best_sad_32;
    logic [13:0]       best_mv_32;
    logic [63:0]       best_sad_16;
    logic [55:0]       best_mv_16;
    logic              done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    sad_min_tracker #(.PIXEL(8), .MVW(7)) dut (
        .clk(clk), .rst_n(rst_n), .abs_outs(abs_outs), .abs_valid(abs_valid),
        .mv_x(mv_x), .mv_y(mv_y), .search_start(search_start),
        .search_last(search_last), .best_sad_32(best_sad_32),
        .best_mv_32(best_mv_32), .best_sad_16(best_sad_16),
        .best_mv_16(best_mv_16), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct packed {
        logic [3:0][7:0]  q;     // per-quadrant fill value, {q3,q2,q1,q0}
        logic signed [6:0] mx;
        logic signed [6:0] my;
        logic [17:0]      e32;
        logic [3:0][15:0] e16;   // {q3,q2,q1,q0}
    } vec_t;

    vec_t tbl [5];

    function automatic logic [8191:0] fill(logic [3:0][7:0] q);
        logic [8191:0] v;
        v = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                v[(32*i+j)*8 +: 8] = q[(i >= 16 ? 2 : 0) + (j >= 16 ? 1 : 0)];
        return v;
    endfunction

    function automatic logic [8191:0] poke(logic [8191:0] v, int i, int j, logic [7:0] val);
        logic [8191:0] r;
        r = v;
        r[(32*i+j)*8 +: 8] = val;
        return r;
    endfunction

    function automatic logic [13:0] tag(int x, int y);
        logic [6:0] a, b;
        a = x[6:0];
        b = y[6:0];
        return {a, b};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string n, logic [17:0] e32, logic [13:0] em32,
                           logic [63:0] e16, logic [55:0] em16);
        chk($sformatf("%s sad32", n), 64'(best_sad_32), 64'(e32));
        chk($sformatf("%s mv32", n),  64'(best_mv_32),  64'(em32));
        chk($sformatf("%s sad16", n), best_sad_16,      e16);
        chk($sformatf("%s mv16", n),  64'(best_mv_16),  64'(em16));
    endtask

    task automatic drive(logic [8191:0] a, logic v, int x, int y, logic st, logic ls);
        @(negedge clk);
        abs_outs     = a;
        abs_valid    = v;
        mv_x         = x[6:0];
        mv_y         = y[6:0];
        search_start = st;
        search_last  = ls;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            abs_valid    = 1'b0;
            search_start = 1'b0;
            search_last  = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] ta, tb_, tc, tx, ty, t;
        logic [8191:0] va, vb, vc;
        int d0;

        tbl[0] = '{q:{8'd1, 8'd1, 8'd1, 8'd1}, mx:7'sd3, my:-7'sd2, e32:18'd1024,
                   e16:{16'd256, 16'd256, 16'd256, 16'd256}};
        tbl[1] = '{q:{8'd255, 8'd255, 8'd255, 8'd255}, mx:-7'sd64, my:7'sd63, e32:18'd261120,
                   e16:{16'd65280, 16'd65280, 16'd65280, 16'd65280}};
        tbl[2] = '{q:{8'd4, 8'd3, 8'd2, 8'd1}, mx:7'sd5, my:7'sd7, e32:18'd2560,
                   e16:{16'd1024, 16'd768, 16'd512, 16'd256}};
        tbl[3] = '{q:{8'd0, 8'd0, 8'd0, 8'd0}, mx:-7'sd1, my:-7'sd1, e32:18'd0,
                   e16:{16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[4] = '{q:{8'd128, 8'd17, 8'd0, 8'd255}, mx:7'sd10, my:-7'sd10, e32:18'd102400,
                   e16:{16'd32768, 16'd4352, 16'd0, 16'd65280}};

        rst_n = 1'b0; abs_outs = '0; abs_valid = 1'b0; mv_x = '0; mv_y = '0;
        search_start = 1'b0; search_last = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 18'h3FFFF, 14'd0, 64'hFFFF_FFFF_FFFF_FFFF, 56'd0);
        chk("reset done", 64'(done), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Each record: start + candidate + last in one cycle
        for (int k = 0; k < 5; k++) begin
            t = {tbl[k].mx, tbl[k].my};
            drive(fill(tbl[k].q), 1'b1, tbl[k].mx, tbl[k].my, 1'b1, 1'b1);
            idle(3);
            @(negedge clk);
            chk($sformatf("vec%0d done", k), 64'(done), 64'd1);
            chk_all($sformatf("vec%0d", k), tbl[k].e32, t, tbl[k].e16, {4{t}});
            $display("[TB] vec %0d sad32=%0d mv=%0h", k, best_sad_32, best_mv_32);
            @(negedge clk);
            chk($sformatf("vec%0d done low", k), 64'(done), 64'd0);
        end

        // Back-to-back 500/300/300, tie keeps B
        ta = tag(1, 1); tb_ = tag(2, 2); tc = tag(3, 3);
        va = poke(poke('0, 0, 0, 8'd250), 0, 1, 8'd250);
        vb = poke(poke('0, 0, 0, 8'd200), 16, 16, 8'd100);
        vc = poke(poke('0, 16, 0, 8'd150), 0, 16, 8'd150);
        d0 = done_cnt;
        drive('0, 1'b0, 0, 0, 1'b1, 1'b0);
        drive(va, 1'b1, 1, 1, 1'b0, 1'b0);
        drive(vb, 1'b1, 2, 2, 1'b0, 1'b0);
        drive(vc, 1'b1, 3, 3, 1'b0, 1'b1);
        idle(3);
        @(negedge clk);
        chk("tie done", 64'(done), 64'd1);
        chk_all("tie", 18'd300, tb_, 64'd0, {ta, ta, ta, tc});
        $display("[TB] tie seq sad32=%0d mv=%0h", best_sad_32, best_mv_32);
        idle(5);
        chk_all("hold", 18'd300, tb_, 64'd0, {ta, ta, ta, tc});
        chk("tie done count", 64'(done_cnt - d0), 64'd1);
        drive('0, 1'b1, 4, 4, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk_all("after last", 18'd0, tag(4, 4), 64'd0, {ta, ta, ta, tc});
        idle(2);
        chk("after last done count", 64'(done_cnt - d0), 64'd1);
        $display("[TB] post-last candidate sad32=%0d", best_sad_32);

        // Independent partitions; stray search_last ignored
        tx = tag(6, -6); ty = tag(-7, 7);
        d0 = done_cnt;
        drive('0, 1'b0, 0, 0, 1'b1, 1'b0);
        drive(fill({8'd0, 8'd0, 8'd0, 8'd4}), 1'b1, 6, -6, 1'b0, 1'b0);
        drive(fill({8'd1, 8'd1, 8'd1, 8'd1}), 1'b1, -7, 7, 1'b0, 1'b0);
        drive('0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(5);
        chk("stray last done count", 64'(done_cnt - d0), 64'd0);
        drive(fill({8'd3, 8'd3, 8'd3, 8'd3}), 1'b1, 9, 9, 1'b0, 1'b1);
        idle(3);
        @(negedge clk);
        chk("part done", 64'(done), 64'd1);
        chk_all("part", 18'd1024, tx, {16'd0, 16'd0, 16'd0, 16'd256}, {tx, tx, tx, ty});
        idle(2);
        chk("part done count", 64'(done_cnt - d0), 64'd1);
        $display("[TB] partition seq sad32=%0d q0=%0d", best_sad_32, best_sad_16[15:0]);

        // Restart while two candidates are in flight
        d0 = done_cnt;
        t = tag(5, 5);
        drive(fill({8'd1, 8'd1, 8'd1, 8'd1}), 1'b1, 1, 1, 1'b1, 1'b0);
        drive(fill({8'd1, 8'd1, 8'd1, 8'd1}), 1'b1, 2, 2, 1'b0, 1'b0);
        drive('0, 1'b0, 0, 0, 1'b1, 1'b0);
        drive(fill({8'd2, 8'd2, 8'd2, 8'd2}), 1'b1, 5, 5, 1'b0, 1'b1);
        idle(3);
        @(negedge clk);
        chk("restart done", 64'(done), 64'd1);
        chk_all("restart", 18'd2048, t, {4{16'd512}}, {4{t}});
        idle(4);
        chk("restart done count", 64'(done_cnt - d0), 64'd1);
        $display("[TB] restart seq sad32=%0d", best_sad_32);

        // Reset one cycle after a last-flagged candidate
        d0 = done_cnt;
        drive(fill({8'd1, 8'd1, 8'd1, 8'd1}), 1'b1, 3, 3, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0; abs_valid = 1'b0; search_start = 1'b0; search_last = 1'b0;
        @(negedge clk);
        chk_all("midrst", 18'h3FFFF, 14'd0, 64'hFFFF_FFFF_FFFF_FFFF, 56'd0);
        repeat (2) @(negedge clk);
        chk("midrst done", 64'(done), 64'd0);
        rst_n = 1'b1;
        idle(4);
        chk("midrst done count", 64'(done_cnt - d0), 64'd0);
        chk_all("midrst after", 18'h3FFFF, 14'd0, 64'hFFFF_FFFF_FFFF_FFFF, 56'd0);
        t = tag(1, -1);
        drive(fill({8'd0, 8'd0, 8'd0, 8'd7}), 1'b1, 1, -1, 1'b1, 1'b1);
        idle(3);
        @(negedge clk);
        chk("post-rst done", 64'(done), 64'd1);
        chk_all("post-rst", 18'd1792, t, {16'd0, 16'd0, 16'd0, 16'd1792}, {4{t}});
        $display("[TB] post-reset search sad32=%0d", best_sad_32);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
SAD_MIN_TRACKER -- requirements
Module: sad_min_tracker

Interface
REQ-001 Parameter PIXEL, default 8: bit width of one absolute-difference value.
REQ-002 Parameter MVW, default 7: width of each signed motion-vector component.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 abs_outs  input  8192: 32x32 absolute differences from the PE array; element (i,j) at bits [(32*i+j+1)*PIXEL-1 : (32*i+j)*PIXEL], i = row, j = column.
REQ-006 abs_valid  input  1: abs_outs holds one complete candidate this cycle.
REQ-007 mv_x, mv_y  input  MVW each, signed: candidate motion vector tag sampled with abs_valid.
REQ-008 search_start  input  1: one-cycle pulse; begins a new search.
REQ-009 search_last  input  1: qualified by abs_valid; marks the final candidate of the search.
REQ-010 best_sad_32  output  18: minimum 32x32 SAD of the current search.
REQ-011 best_mv_32  output  2*MVW: {mv_x, mv_y} of best_sad_32.
REQ-012 best_sad_16  output  64: four 16-bit quadrant minima; quadrant q at bits [16q+15:16q].
REQ-013 best_mv_16  output  8*MVW: four {mv_x, mv_y} tags; quadrant q at bits [2*MVW*(q+1)-1 : 2*MVW*q].
REQ-014 done  output  1: one-cycle pulse; all best_* outputs are final for the search.

Function
REQ-015 Quadrants: q0 = rows 0-15/cols 0-15, q1 = rows 0-15/cols 16-31, q2 = rows 16-31/cols 0-15, q3 = rows 16-31/cols 16-31.
REQ-016 Stage 1 (registered): 64 half-row sums of 16 values each, 12 bits each; valid, last and MV tag are registered alongside.
REQ-017 Stage 2 (registered): four quadrant SADs, 16 bits each, each the sum of 16 half-row sums; tag, valid and last are carried.
REQ-018 Stage 3 (registered): full SAD = sum of the four quadrants, 18 bits, with no truncation anywhere; compare-and-update the five minima.
REQ-019 Latency: a candidate with abs_valid at edge t updates the minima at edge t+3; back-to-back candidates are accepted every cycle; no stall input.
REQ-020 Update rule: each partition updates independently, and only when the new SAD is strictly less than the stored minimum.
REQ-021 Tie rule: on equal SAD the earliest candidate is kept.
REQ-022 search_start clears all five minima to all-ones, clears all MV tags to 0, and kills every in-flight valid in stages 1-3 on the same edge.
REQ-023 If search_start and abs_valid occur in the same cycle, that candidate belongs to the new search and is evaluated.
REQ-024 done pulses high for one cycle on the edge where the search_last candidate completes stage 3; outputs reflect that candidate's update.
REQ-025 best_* outputs hold their values after done until the next search_start.
REQ-026 Candidates arriving after search_last and before the next search_start are still evaluated; no lock is applied.
REQ-027 search_last without abs_valid is ignored.

Reset
REQ-028 While rst_n is low: best_sad_32 = 18'h3FFFF, every best_sad_16 lane = 16'hFFFF, all MV outputs = 0, done = 0, and all pipeline valid/last flags = 0.
REQ-029 Reset asserted mid-search discards all in-flight candidates; no done is produced for them.

Verification
REQ-030 Reset, then search_start, then one candidate with all elements 1, mv = (3,-2), last = 1 -> 3 cycles later: done = 1, best_sad_32 = 1024, every quadrant = 256, all tags = (3,-2).
REQ-031 Three back-to-back candidates with full SAD 500, 300, 300 (tags A, B, C), last on C -> best_sad_32 = 300 with tag B (tie keeps earliest); done pulses exactly once.
REQ-032 Candidate X has only q0 elements = 4 (q0 SAD = 1024, others 0); candidate Y has all elements = 1 -> q0 best = Y with 256, q1-q3 best = X with 0, full best = X with 1024.
REQ-033 All elements = 255 -> best_sad_32 = 261120 and quadrant SAD = 65280, with no overflow.
REQ-034 Issue 2 candidates, assert search_start while both are in flight, then one candidate with last = 1 -> result reflects only the post-start candidate; exactly one done.
REQ-035 Drop rst_n one cycle after a last-flagged candidate -> no done, all outputs at reset values, and normal operation on the next search.
